// File: rtl/bank_group_timed_if.sv
// Command/data bus between the channel command decoder and a timed bank group.
interface bank_group_timed_if #(
  parameter int unsigned BAWIDTH      = 2,
  parameter int unsigned COLWIDTH     = 4,
  parameter int unsigned CHWIDTH      = 4,
  parameter int unsigned DEVICE_WIDTH = 4
);
  localparam int unsigned BANKSPERGROUP = 2 ** BAWIDTH;

  logic                     cmd_valid;
  logic [2:0]               cmd;
  logic [BAWIDTH-1:0]       cmd_bank;
  logic [CHWIDTH-1:0]       cmd_row;
  logic [COLWIDTH-1:0]      cmd_col;
  logic [DEVICE_WIDTH-1:0]  dqin;
  logic [DEVICE_WIDTH-1:0]  dqout;
  logic                     rd_valid;
  logic                     cmd_err;
  logic [BANKSPERGROUP-1:0] bank_open;

  modport master (
    output cmd_valid, cmd, cmd_bank, cmd_row, cmd_col, dqin,
    input  dqout, rd_valid, cmd_err, bank_open
  );

  modport slave (
    input  cmd_valid, cmd, cmd_bank, cmd_row, cmd_col, dqin,
    output dqout, rd_valid, cmd_err, bank_open
  );
endinterface

// File: rtl/bank_group_timed.sv
// Group of banks behind one command bus: per-bank open/active/precharge FSMs with
// tRCD/tRAS/tRP enforcement, illegal-command rejection and a CL-deep read pipeline.
module bank_group_timed #(
  parameter int unsigned BAWIDTH      = 2,
  parameter int unsigned COLWIDTH     = 4,
  parameter int unsigned CHWIDTH      = 4,
  parameter int unsigned DEVICE_WIDTH = 4,
  parameter int unsigned TRCD         = 3,
  parameter int unsigned TRP          = 3,
  parameter int unsigned TRAS         = 6,
  parameter int unsigned CL           = 4
) (
  input logic               clk,
  input logic               rst,
  bank_group_timed_if.slave bus
);
  localparam int unsigned BANKSPERGROUP = 2 ** BAWIDTH;
  localparam int unsigned MaxT = (TRCD > TRP) ? ((TRCD > TRAS) ? TRCD : TRAS)
                                              : ((TRP > TRAS) ? TRP : TRAS);
  localparam int unsigned TW       = $clog2(MaxT + 1);
  localparam int unsigned AW       = BAWIDTH + CHWIDTH + COLWIDTH;
  localparam int unsigned MemWords = 2 ** AW;

  // Timer loads count down to 0 on the last non-final cycle of OPENING/CLOSING.
  localparam logic [TW-1:0] TrcdLoad = TW'((TRCD > 1) ? TRCD - 2 : 0);
  localparam logic [TW-1:0] TrpLoad  = TW'((TRP > 1) ? TRP - 2 : 0);
  localparam logic [TW-1:0] TrasLoad = TW'(TRAS - 1);

  localparam logic [2:0] CmdNop  = 3'd0;
  localparam logic [2:0] CmdAct  = 3'd1;
  localparam logic [2:0] CmdRd   = 3'd2;
  localparam logic [2:0] CmdWr   = 3'd3;
  localparam logic [2:0] CmdPre  = 3'd4;
  localparam logic [2:0] CmdPrea = 3'd5;

  typedef enum logic [1:0] {StIdle, StOpening, StActive, StClosing} bank_st_e;

  bank_st_e            state_q [BANKSPERGROUP];
  bank_st_e            state_d [BANKSPERGROUP];
  logic [TW-1:0]       tmr_q   [BANKSPERGROUP];
  logic [TW-1:0]       tmr_d   [BANKSPERGROUP];
  logic [TW-1:0]       ras_q   [BANKSPERGROUP];
  logic [TW-1:0]       ras_d   [BANKSPERGROUP];
  logic [CHWIDTH-1:0]  row_q   [BANKSPERGROUP];
  logic [CHWIDTH-1:0]  row_d   [BANKSPERGROUP];

  bank_st_e sel_st;
  logic     sel_ras_done;
  logic     prea_ok;
  logic     cmd_ok;
  logic     accept;
  logic     err_d;
  logic     err_q;
  logic     rd_issue;
  logic     wr_issue;

  logic [DEVICE_WIDTH-1:0]  mem [MemWords];
  logic [AW-1:0]            mem_addr;
  logic [CL-1:0]            pv_q;
  logic [DEVICE_WIDTH-1:0]  pd_q [CL];
  logic [DEVICE_WIDTH-1:0]  hold_q;
  logic [BANKSPERGROUP-1:0] bank_open;

  // Command legality against the current bank states.
  always_comb begin
    sel_st       = state_q[bus.cmd_bank];
    sel_ras_done = (ras_q[bus.cmd_bank] == '0);
    prea_ok      = 1'b1;
    for (int b = 0; b < BANKSPERGROUP; b++) begin
      if (state_q[b] == StOpening || (state_q[b] == StActive && ras_q[b] != '0)) begin
        prea_ok = 1'b0;
      end
    end
    case (bus.cmd)
      CmdNop:       cmd_ok = 1'b1;
      CmdAct:       cmd_ok = (sel_st == StIdle);
      CmdRd, CmdWr: cmd_ok = (sel_st == StActive);
      CmdPre:       cmd_ok = (sel_st == StIdle) || (sel_st == StActive && sel_ras_done);
      CmdPrea:      cmd_ok = prea_ok;
      default:      cmd_ok = 1'b0;
    endcase
    accept   = bus.cmd_valid && cmd_ok;
    err_d    = bus.cmd_valid && !cmd_ok;
    rd_issue = accept && (bus.cmd == CmdRd);
    wr_issue = accept && (bus.cmd == CmdWr);
  end

  // Per-bank next state: timers run, then accepted commands override.
  always_comb begin
    for (int b = 0; b < BANKSPERGROUP; b++) begin
      state_d[b] = state_q[b];
      tmr_d[b]   = tmr_q[b];
      ras_d[b]   = (ras_q[b] != '0) ? ras_q[b] - TW'(1) : '0;
      row_d[b]   = row_q[b];
      unique case (state_q[b])
        StOpening: begin
          if (tmr_q[b] == '0) state_d[b] = StActive;
          else                tmr_d[b]   = tmr_q[b] - TW'(1);
        end
        StClosing: begin
          if (tmr_q[b] == '0) state_d[b] = StIdle;
          else                tmr_d[b]   = tmr_q[b] - TW'(1);
        end
        default: ;
      endcase
      if (accept && bus.cmd == CmdAct && bus.cmd_bank == BAWIDTH'(b)) begin
        state_d[b] = (TRCD > 1) ? StOpening : StActive;
        tmr_d[b]   = TrcdLoad;
        ras_d[b]   = TrasLoad;
        row_d[b]   = bus.cmd_row;
      end
      if (accept && state_q[b] == StActive &&
          ((bus.cmd == CmdPre && bus.cmd_bank == BAWIDTH'(b)) || bus.cmd == CmdPrea)) begin
        state_d[b] = (TRP > 1) ? StClosing : StIdle;
        tmr_d[b]   = TrpLoad;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < BANKSPERGROUP; b++) begin
        state_q[b] <= StIdle;
        tmr_q[b]   <= '0;
        ras_q[b]   <= '0;
        row_q[b]   <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int b = 0; b < BANKSPERGROUP; b++) begin
        state_q[b] <= state_d[b];
        tmr_q[b]   <= tmr_d[b];
        ras_q[b]   <= ras_d[b];
        row_q[b]   <= row_d[b];
      end
      err_q <= err_d;
    end
  end

  always_comb begin
    for (int b = 0; b < BANKSPERGROUP; b++) begin
      bank_open[b] = (state_q[b] == StActive);
    end
  end

  assign mem_addr = {bus.cmd_bank, row_q[bus.cmd_bank], bus.cmd_col};

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_issue) mem[mem_addr] <= bus.dqin;
  end

  // Read data is captured at issue, so a later PRE cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q   <= '0;
      hold_q <= '0;
      for (int i = 0; i < CL; i++) pd_q[i] <= '0;
    end else begin
      pv_q[0] <= rd_issue;
      pd_q[0] <= mem[mem_addr];
      for (int i = 1; i < CL; i++) begin
        pv_q[i] <= pv_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
      if (pv_q[CL-1]) hold_q <= pd_q[CL-1];
    end
  end

  assign bus.rd_valid  = pv_q[CL-1];
  assign bus.dqout     = pv_q[CL-1] ? pd_q[CL-1] : hold_q;
  assign bus.cmd_err   = err_q;
  assign bus.bank_open = bank_open;

endmodule

// File: tb/tb_bank_group_timed.sv
// Directed bench for bank_group_timed: timestamp-based bank model checked every cycle,
// plus literal expectations taken from hand-worked command sequences.
module tb_bank_group_timed;
  localparam int TRCD = 3;
  localparam int TRP  = 3;
  localparam int TRAS = 6;
  localparam int CL   = 4;
  localparam int NB   = 4;

  localparam int MIdle = 0, MOpening = 1, MActive = 2, MClosing = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bank_group_timed_if bus ();

  bank_group_timed dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: banks described by when they were last activated / precharged.
  typedef struct {int due; logic [3:0] d;} rd_t;
  int         cyc = 0;
  int         act_t [NB];
  int         pre_t [NB];
  int         row_m [NB];
  logic [3:0] mem_m [int];
  rd_t        rq [$];
  logic       exp_valid, exp_err;
  logic [3:0] exp_dq;
  logic [3:0] exp_open;
  bit         model_ok = 0;

  function automatic int bst(input int b, input int c);
    if (act_t[b] < 0) return MIdle;
    if (pre_t[b] > act_t[b]) return (c >= pre_t[b] + TRP) ? MIdle : MClosing;
    return (c >= act_t[b] + TRCD) ? MActive : MOpening;
  endfunction

  always @(posedge clk) begin
    logic ok;
    int   b, key;
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        act_t[i] = -1; pre_t[i] = -1; row_m[i] = 0;
      end
      rq.delete();
      exp_err = 0; exp_dq = 0; model_ok = 1;
    end else begin
      b  = int'(bus.cmd_bank);
      ok = 1;
      case (bus.cmd)
        3'd0: ok = 1;
        3'd1: ok = (bst(b, cyc) == MIdle);
        3'd2, 3'd3: ok = (bst(b, cyc) == MActive);
        3'd4: ok = (bst(b, cyc) == MIdle) ||
                   (bst(b, cyc) == MActive && cyc >= act_t[b] + TRAS);
        3'd5: for (int i = 0; i < NB; i++)
                if (bst(i, cyc) == MOpening || (bst(i, cyc) == MActive && cyc < act_t[i] + TRAS))
                  ok = 0;
        default: ok = 0;
      endcase
      exp_err = bus.cmd_valid && !ok;
      if (bus.cmd_valid && ok) begin
        key = b * 256 + row_m[b] * 16 + int'(bus.cmd_col);
        case (bus.cmd)
          3'd1: begin act_t[b] = cyc; row_m[b] = int'(bus.cmd_row); end
          3'd2: rq.push_back('{cyc + CL, mem_m.exists(key) ? mem_m[key] : 4'h0});
          3'd3: mem_m[key] = bus.dqin;
          3'd4: if (bst(b, cyc) == MActive) pre_t[b] = cyc;
          3'd5: for (int i = 0; i < NB; i++) if (bst(i, cyc) == MActive) pre_t[i] = cyc;
          default: ;
        endcase
      end
    end
    cyc++;
    exp_valid = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_valid = 1; exp_dq = rq[0].d; void'(rq.pop_front());
    end
    for (int i = 0; i < NB; i++) exp_open[i] = (bst(i, cyc) == MActive);
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("m_rd_valid", 32'(bus.rd_valid), 32'(exp_valid));
      check("m_cmd_err", 32'(bus.cmd_err), 32'(exp_err));
      check("m_bank_open", 32'(bus.bank_open), 32'(exp_open));
      check("m_dqout", 32'(bus.dqout), 32'(exp_dq));
    end
  end

  task automatic drive(input logic v, input int c, input int b, input int r, input int col,
                       input int d);
    bus.cmd_valid = v;
    bus.cmd       = 3'(c);
    bus.cmd_bank  = 2'(b);
    bus.cmd_row   = 4'(r);
    bus.cmd_col   = 4'(col);
    bus.dqin      = 4'(d);
    @(negedge clk);
  endtask

  task automatic nop(input int n);
    repeat (n) drive(1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    nop(2);
    rst = 1'b0;
  endtask

  initial begin
    bus.cmd_valid = 0; bus.cmd = 0; bus.cmd_bank = 0;
    bus.cmd_row = 0; bus.cmd_col = 0; bus.dqin = 0;
    @(negedge clk);

    // Basic ACT / WR / RD
    do_reset;
    check("rst_rd_valid", 32'(bus.rd_valid), 0);
    check("rst_cmd_err", 32'(bus.cmd_err), 0);
    check("rst_bank_open", 32'(bus.bank_open), 0);
    check("rst_dqout", 32'(bus.dqout), 0);
    drive(1, 1, 0, 5, 0, 0);
    nop(1);
    check("s1_open_t2", 32'(bus.bank_open), 0);
    nop(1);
    check("s1_open_t3", 32'(bus.bank_open), 32'h1);
    drive(1, 3, 0, 0, 2, 4'hA);
    drive(1, 2, 0, 0, 2, 0);
    nop(2);
    check("s1_valid_t7", 32'(bus.rd_valid), 0);
    nop(1);
    check("s1_valid_t8", 32'(bus.rd_valid), 1);
    check("s1_dq_t8", 32'(bus.dqout), 32'hA);
    nop(1);
    check("s1_valid_t9", 32'(bus.rd_valid), 0);
    check("s1_dq_hold", 32'(bus.dqout), 32'hA);

    // tRCD / tRAS / tRP violations
    do_reset;
    drive(1, 1, 1, 2, 0, 0);
    nop(1);
    drive(1, 2, 1, 0, 0, 0);
    check("s2_rd_early_err", 32'(bus.cmd_err), 1);
    nop(2);
    check("s2_err_clear", 32'(bus.cmd_err), 0);
    drive(1, 4, 1, 0, 0, 0);
    check("s2_pre_early_err", 32'(bus.cmd_err), 1);
    check("s2_open_t6", 32'(bus.bank_open), 32'h2);
    drive(1, 4, 1, 0, 0, 0);
    check("s2_pre_ok_err", 32'(bus.cmd_err), 0);
    check("s2_open_t7", 32'(bus.bank_open), 0);
    nop(1);
    drive(1, 1, 1, 2, 0, 0);
    check("s2_act_early_err", 32'(bus.cmd_err), 1);
    drive(1, 1, 1, 2, 0, 0);
    check("s2_act_ok_err", 32'(bus.cmd_err), 0);
    nop(3);
    check("s2_open_t13", 32'(bus.bank_open), 32'h2);

    // Four banks, back-to-back reads
    do_reset;
    for (int b = 0; b < NB; b++) drive(1, 1, b, 3, 0, 0);
    nop(2);
    check("s3_all_open", 32'(bus.bank_open), 32'hF);
    for (int b = 0; b < NB; b++) drive(1, 3, b, 0, 7, b + 1);
    for (int b = 0; b < NB; b++) drive(1, 2, b, 0, 7, 0);
    for (int b = 0; b < NB; b++) begin
      check("s3_valid", 32'(bus.rd_valid), 1);
      check("s3_dq", 32'(bus.dqout), 32'(b + 1));
      nop(1);
    end
    check("s3_valid_end", 32'(bus.rd_valid), 0);

    // PREA rejection and acceptance
    do_reset;
    drive(1, 1, 0, 1, 0, 0);
    nop(1);
    drive(1, 1, 2, 1, 0, 0);
    nop(3);
    drive(1, 5, 0, 0, 0, 0);
    check("s4_prea_err", 32'(bus.cmd_err), 1);
    check("s4_open_kept", 32'(bus.bank_open), 32'h5);
    nop(1);
    drive(1, 5, 0, 0, 0, 0);
    check("s4_prea_ok", 32'(bus.cmd_err), 0);
    check("s4_open_closed", 32'(bus.bank_open), 0);

    // Reset flushes an in-flight read
    do_reset;
    drive(1, 1, 0, 1, 0, 0);
    nop(2);
    drive(1, 3, 0, 0, 0, 5);
    nop(6);
    drive(1, 2, 0, 0, 0, 0);
    nop(1);
    rst = 1'b1;
    nop(1);
    rst = 1'b0;
    check("s5_open_after_rst", 32'(bus.bank_open), 0);
    check("s5_valid_t13", 32'(bus.rd_valid), 0);
    drive(1, 2, 0, 0, 0, 0);
    check("s5_rd_idle_err", 32'(bus.cmd_err), 1);
    for (int k = 0; k < 7; k++) begin
      check("s5_no_valid", 32'(bus.rd_valid), 0);
      nop(1);
    end

    // Opcode decoding and cmd_valid gating
    do_reset;
    drive(1, 7, 0, 0, 0, 0);
    check("s6_op7_err", 32'(bus.cmd_err), 1);
    drive(1, 0, 0, 0, 0, 0);
    check("s6_nop_err", 32'(bus.cmd_err), 0);
    drive(1, 6, 0, 0, 0, 0);
    check("s6_op6_err", 32'(bus.cmd_err), 1);
    drive(0, 1, 0, 0, 0, 0);
    check("s6_invalid_err", 32'(bus.cmd_err), 0);
    nop(3);
    check("s6_invalid_act", 32'(bus.bank_open), 0);

    nop(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1);
  end
endmodule
